// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS core: memory sizes, opcode/funct
// encodings and the ALU operation enum.
package mips_pkg;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/mips_mem.sv
// Word-addressed 64x32 memory: combinational read, synchronous write.
// Contents are never reset; benches preload the array named mem.
module mips_mem
  import mips_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [5:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem [0:WORDS-1];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS32 subset core (add/sub/and/or/slt/addi/lw/sw/beq/j).
// Define MIPS_TRACE_EN to print a per-instruction execution trace in simulation.
module mips_cpu
  import mips_pkg::*;
(
  input logic rst,
  input logic clk
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [0:31];
  logic [31:0] instr, dmem_rdata;

  logic        reg_we, mem_we, mem_to_reg, use_imm, branch, jump;
  logic [4:0]  dst;
  alu_op_e     alu_op;
  logic [31:0] rs_val, rt_val, imm_sext, alu_b, alu_res, wb_data;
  logic [31:0] pc_plus4;
  logic        dmem_we;

  wire [5:0]  opcode = instr[31:26];
  wire [4:0]  rs     = instr[25:21];
  wire [4:0]  rt     = instr[20:16];
  wire [4:0]  rd     = instr[15:11];
  wire [5:0]  funct  = instr[5:0];
  wire [15:0] imm    = instr[15:0];
  wire [25:0] target = instr[25:0];

  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  mips_mem #(.WORDS(IMEM_WORDS)) mips_i_mem (
    .clk_i   (clk),
    .we_i    (1'b0),
    .addr_i  (pc_q[7:2]),
    .wdata_i (32'd0),
    .rdata_o (instr)
  );

  // Stores are suppressed while rst is high because memory has no reset of its own.
  assign dmem_we = mem_we & ~rst;

  mips_mem #(.WORDS(DMEM_WORDS)) mips_d_mem (
    .clk_i   (clk),
    .we_i    (dmem_we),
    .addr_i  (alu_res[7:2]),
    .wdata_i (rt_val),
    .rdata_o (dmem_rdata)
  );

  always_comb begin
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    use_imm    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    dst        = rt;
    alu_op     = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        dst = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin reg_we = 1'b1; use_imm = 1'b1; end
      OP_LW:   begin reg_we = 1'b1; use_imm = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin mem_we = 1'b1; use_imm = 1'b1; end
      OP_BEQ:  branch = 1'b1;
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign alu_b    = use_imm ? imm_sext : rt_val;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      default: alu_res = 32'd0;
    endcase
  end

  assign wb_data  = mem_to_reg ? dmem_rdata : alu_res;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (jump)
      pc_d = {pc_plus4[31:28], target, 2'b00};
    else if (branch && (rs_val == rt_val))
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'd0;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (reg_we && (dst != 5'd0)) begin
      regs_q[dst] <= wb_data;
    end
  end

`ifdef MIPS_TRACE_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_we)
        $display("trace pc=%08h instr=%08h st [%08h]=%08h", pc_q, instr, alu_res, rt_val);
      else if (reg_we)
        $display("trace pc=%08h instr=%08h r%0d=%08h", pc_q, instr, dst, wb_data);
      else
        $display("trace pc=%08h instr=%08h", pc_q, instr);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: preloads memories hierarchically and checks
// registers, PC and data memory against hand-computed values.
module tb_mips_cpu;

  logic rst;
  logic clk;
  int   n_checks;
  int   n_fail;

  logic [31:0] prog  [0:63];
  logic [31:0] dinit [0:63];

  mips_cpu dut (
    .rst (rst),
    .clk (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] a, b, c, d;
    a = op; b = rs; c = rt; d = imm;
    return {a[5:0], b[4:0], c[4:0], d[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
    logic [31:0] a, b, c, d;
    a = fn; b = rd; c = rs; d = rt;
    return {6'h00, c[4:0], d[4:0], b[4:0], 5'd0, a[5:0]};
  endfunction

  task automatic clear_images();
    for (int i = 0; i < 64; i++) begin
      prog[i]  = 32'd0;
      dinit[i] = 32'd0;
    end
  endtask

  // Hold reset, load both memories, release on a falling edge.
  task automatic boot();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      dut.mips_i_mem.mem[i] = prog[i];
      dut.mips_d_mem.mem[i] = dinit[i];
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_alu_prog();
    clear_images();
    prog[0] = enc_i(8, 0, 1, 5);
    prog[1] = enc_i(8, 0, 2, -3);
    prog[2] = enc_r(32'h20, 3, 1, 2);
    prog[3] = enc_r(32'h22, 4, 1, 2);
    prog[4] = enc_r(32'h2A, 5, 2, 1);
    prog[5] = enc_r(32'h24, 6, 1, 2);
    prog[6] = enc_r(32'h25, 7, 1, 2);
  endtask

  task automatic test_reset();
    int bad;
    load_alu_prog();
    boot();
    run(4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut.pc_q !== 32'd0) begin
      n_fail++; $display("FAIL reset_pc: got %08h want 00000000", dut.pc_q);
    end
    bad = 0;
    for (int i = 1; i < 32; i++) if (dut.regs_q[i] !== 32'd0) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_regs: %0d nonzero registers, want 0", bad);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.pc_q !== 32'd0 || dut.regs_q[1] !== 32'd0) begin
      n_fail++; $display("FAIL reset_hold: pc=%08h r1=%08h want 0/0", dut.pc_q, dut.regs_q[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    run(1);
    n_checks++;
    if (dut.pc_q !== 32'd4 || dut.regs_q[1] !== 32'd5) begin
      n_fail++; $display("FAIL reset_resume: pc=%08h r1=%08h want 00000004/00000005", dut.pc_q, dut.regs_q[1]);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp [1:7];
    exp[1] = 32'd5; exp[2] = 32'hFFFF_FFFD; exp[3] = 32'd2; exp[4] = 32'd8;
    exp[5] = 32'd1; exp[6] = 32'd5; exp[7] = 32'hFFFF_FFFD;
    load_alu_prog();
    boot();
    run(7);
    for (int i = 1; i <= 7; i++) begin
      n_checks++;
      if (dut.regs_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL alu_r%0d: got %08h want %08h", i, dut.regs_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_memory();
    clear_images();
    dinit[0] = 32'h11;
    dinit[1] = 32'h22;
    prog[0] = enc_i(32'h23, 0, 1, 0);
    prog[1] = enc_i(32'h23, 0, 2, 4);
    prog[2] = enc_r(32'h20, 3, 1, 2);
    prog[3] = enc_i(32'h2B, 0, 3, 8);
    prog[4] = enc_i(32'h23, 0, 4, 8);
    boot();
    run(5);
    n_checks++;
    if (dut.mips_d_mem.mem[2] !== 32'h33) begin
      n_fail++; $display("FAIL mem_store: got %08h want 00000033", dut.mips_d_mem.mem[2]);
    end
    n_checks++;
    if (dut.regs_q[4] !== 32'h33) begin
      n_fail++; $display("FAIL mem_load_after_store: got %08h want 00000033", dut.regs_q[4]);
    end
    n_checks++;
    if (dut.regs_q[2] !== 32'h22) begin
      n_fail++; $display("FAIL mem_load_offset: got %08h want 00000022", dut.regs_q[2]);
    end
  endtask

  task automatic test_branch();
    logic [31:0] pcs [0:5];
    pcs[0] = 32'd0; pcs[1] = 32'd4; pcs[2] = 32'd12;
    pcs[3] = 32'd16; pcs[4] = 32'd20; pcs[5] = 32'd24;
    clear_images();
    prog[0] = enc_i(8, 0, 3, 1);
    prog[1] = enc_i(4, 0, 0, 1);
    prog[2] = enc_i(8, 0, 1, 9);
    prog[3] = enc_i(8, 0, 2, 7);
    prog[4] = enc_i(4, 2, 0, 1);
    prog[5] = enc_i(8, 0, 4, 4);
    prog[6] = enc_i(8, 0, 5, 5);
    boot();
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (dut.pc_q !== pcs[k]) begin
        n_fail++; $display("FAIL branch_pc_step%0d: got %08h want %08h", k, dut.pc_q, pcs[k]);
      end
      run(1);
    end
    n_checks++;
    if (dut.regs_q[1] !== 32'd0 || dut.regs_q[2] !== 32'd7 || dut.regs_q[4] !== 32'd4) begin
      n_fail++; $display("FAIL branch_regs: r1=%08h r2=%08h r4=%08h want 0/7/4",
                         dut.regs_q[1], dut.regs_q[2], dut.regs_q[4]);
    end
  endtask

  task automatic test_jump_wrap();
    clear_images();
    prog[0] = enc_i(8, 1, 1, 1);
    prog[7] = {6'h02, 26'd0};
    boot();
    run(8);
    n_checks++;
    if (dut.pc_q !== 32'd0 || dut.regs_q[1] !== 32'd1) begin
      n_fail++; $display("FAIL jump_first_loop: pc=%08h r1=%08h want 0/1", dut.pc_q, dut.regs_q[1]);
    end
    run(9);
    n_checks++;
    if (dut.pc_q !== 32'd4 || dut.regs_q[1] !== 32'd3) begin
      n_fail++; $display("FAIL jump_counter: pc=%08h r1=%08h want 4/3", dut.pc_q, dut.regs_q[1]);
    end
  endtask

  task automatic test_zero_reg();
    int bad;
    clear_images();
    dinit[0] = 32'hA5A5_0001;
    prog[0] = enc_i(8, 0, 0, 7);
    prog[1] = enc_i(8, 0, 1, 3);
    prog[2] = 32'hFC00_0000;
    prog[3] = enc_r(32'h3F, 2, 1, 1);
    prog[4] = 32'h0000_0000;
    boot();
    run(5);
    n_checks++;
    if (dut.regs_q[0] !== 32'd0) begin
      n_fail++; $display("FAIL zero_reg: got %08h want 00000000", dut.regs_q[0]);
    end
    n_checks++;
    if (dut.regs_q[1] !== 32'd3 || dut.pc_q !== 32'd20) begin
      n_fail++; $display("FAIL nop_flow: r1=%08h pc=%08h want 3/00000014", dut.regs_q[1], dut.pc_q);
    end
    bad = 0;
    for (int i = 2; i < 32; i++) if (dut.regs_q[i] !== 32'd0) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL unknown_op_regs: %0d registers written, want 0", bad);
    end
    n_checks++;
    if (dut.mips_d_mem.mem[0] !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL unknown_op_mem: got %08h want a5a50001", dut.mips_d_mem.mem[0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_jump_wrap();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
